// File: rtl/arc4_encrypt.sv
// ARC4 stream-cipher engine over three external byte memories.
//   clk, rst       : single clock, asynchronous active-high reset
//   en, rdy        : start request (taken only while rdy=1), idle/ready flag
//   key            : KEY_BYTES-byte key, big-endian, latched when en is accepted
//   s_addr/s_wrdata/s_wren/s_rddata : S-box memory, 1-cycle read latency
//   pt_addr/pt_rddata               : plaintext memory, 1-cycle read latency
//   ct_addr/ct_wrdata/ct_wren       : ciphertext memory, write only
// Memory format: byte 0 = length L, bytes 1..L = message.
// Timing after the accepting edge: INIT 256 cycles, KSA 6 cycles per index
// (1536), LEN 3 cycles, PRGA 9 cycles per byte. rdy is low for 1795 + 9*L cycles.
// All outputs are registered.
module arc4_encrypt #(
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren,
  input  logic [7:0]             s_rddata,
  output logic [7:0]             pt_addr,
  input  logic [7:0]             pt_rddata,
  output logic [7:0]             ct_addr,
  output logic [7:0]             ct_wrdata,
  output logic                   ct_wren
);

  typedef enum logic [2:0] {StIdle, StInit, StKsa, StLen, StPrga} state_e;

  state_e                 state_q;
  logic [3:0]             phase_q;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [7:0]             i_q, j_q, kidx_q, si_q, sj_q, pt_q, len_q, k_q;
  logic [7:0]             key_byte, ksa_j, prga_j;

  // Key byte for the current KSA index (kidx_q tracks i mod KEY_BYTES).
  always_comb begin
    key_byte = 8'h00;
    for (int unsigned b = 0; b < KEY_BYTES; b++) begin
      if (kidx_q == 8'(b)) key_byte = key_q[8*(KEY_BYTES-1-b) +: 8];
    end
  end

  assign ksa_j  = j_q + s_rddata + key_byte;
  assign prga_j = j_q + s_rddata;

  // Each swap reads S[i] and S[j] into si_q/sj_q before either write, so
  // i == j writes the same value back twice and S is unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      key_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      kidx_q    <= '0;
      si_q      <= '0;
      sj_q      <= '0;
      pt_q      <= '0;
      len_q     <= '0;
      k_q       <= '0;
      rdy       <= 1'b1;
      s_addr    <= '0;
      s_wrdata  <= '0;
      s_wren    <= 1'b0;
      pt_addr   <= '0;
      ct_addr   <= '0;
      ct_wrdata <= '0;
      ct_wren   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          phase_q <= '0;
          if (en) begin
            key_q    <= key;
            rdy      <= 1'b0;
            i_q      <= '0;
            j_q      <= '0;
            kidx_q   <= '0;
            s_addr   <= '0;
            s_wrdata <= '0;
            s_wren   <= 1'b1;
            state_q  <= StInit;
          end
        end

        StInit: begin
          if (s_addr == 8'hFF) begin
            s_wren  <= 1'b0;
            s_addr  <= '0;
            phase_q <= '0;
            state_q <= StKsa;
          end else begin
            s_addr   <= s_addr + 8'd1;
            s_wrdata <= s_wrdata + 8'd1;
          end
        end

        StKsa: begin
          case (phase_q)
            4'd0: phase_q <= 4'd1;
            4'd1: begin
              si_q    <= s_rddata;
              j_q     <= ksa_j;
              s_addr  <= ksa_j;
              phase_q <= 4'd2;
            end
            4'd2: phase_q <= 4'd3;
            4'd3: begin
              sj_q     <= s_rddata;
              s_addr   <= i_q;
              s_wrdata <= s_rddata;
              s_wren   <= 1'b1;
              phase_q  <= 4'd4;
            end
            4'd4: begin
              s_addr   <= j_q;
              s_wrdata <= si_q;
              phase_q  <= 4'd5;
            end
            default: begin
              s_wren  <= 1'b0;
              phase_q <= '0;
              if (i_q == 8'hFF) begin
                i_q     <= '0;
                s_addr  <= '0;
                pt_addr <= '0;
                state_q <= StLen;
              end else begin
                i_q    <= i_q + 8'd1;
                s_addr <= i_q + 8'd1;
                kidx_q <= (kidx_q == 8'(KEY_BYTES - 1)) ? 8'd0 : kidx_q + 8'd1;
              end
            end
          endcase
        end

        StLen: begin
          case (phase_q)
            4'd0: phase_q <= 4'd1;
            4'd1: begin
              len_q     <= pt_rddata;
              ct_addr   <= '0;
              ct_wrdata <= pt_rddata;
              ct_wren   <= 1'b1;
              phase_q   <= 4'd2;
            end
            default: begin
              ct_wren <= 1'b0;
              phase_q <= '0;
              if (len_q == 8'd0) begin
                rdy     <= 1'b1;
                state_q <= StIdle;
              end else begin
                i_q     <= 8'd1;
                j_q     <= '0;
                k_q     <= 8'd1;
                s_addr  <= 8'd1;
                pt_addr <= 8'd1;
                state_q <= StPrga;
              end
            end
          endcase
        end

        StPrga: begin
          case (phase_q)
            4'd0: phase_q <= 4'd1;
            4'd1: begin
              si_q    <= s_rddata;
              pt_q    <= pt_rddata;
              j_q     <= prga_j;
              s_addr  <= prga_j;
              phase_q <= 4'd2;
            end
            4'd2: phase_q <= 4'd3;
            4'd3: begin
              sj_q     <= s_rddata;
              s_addr   <= i_q;
              s_wrdata <= s_rddata;
              s_wren   <= 1'b1;
              phase_q  <= 4'd4;
            end
            4'd4: begin
              s_addr   <= j_q;
              s_wrdata <= si_q;
              phase_q  <= 4'd5;
            end
            4'd5: begin
              // Pad index is unchanged by the swap: S[i]+S[j] = sj + si.
              s_wren  <= 1'b0;
              s_addr  <= si_q + sj_q;
              phase_q <= 4'd6;
            end
            4'd6: phase_q <= 4'd7;
            4'd7: begin
              ct_addr   <= k_q;
              ct_wrdata <= s_rddata ^ pt_q;
              ct_wren   <= 1'b1;
              phase_q   <= 4'd8;
            end
            default: begin
              ct_wren <= 1'b0;
              phase_q <= '0;
              if (k_q == len_q) begin
                rdy     <= 1'b1;
                state_q <= StIdle;
              end else begin
                k_q     <= k_q + 8'd1;
                i_q     <= i_q + 8'd1;
                s_addr  <= i_q + 8'd1;
                pt_addr <= k_q + 8'd1;
              end
            end
          endcase
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_encrypt.sv
module tb_arc4_encrypt;
  localparam int KB = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          rdy;
  logic [8*KB-1:0] key = '0;
  logic [7:0]    s_addr, s_wrdata, s_rddata, pt_addr, pt_rddata, ct_addr, ct_wrdata;
  logic          s_wren, ct_wren;

  logic [7:0] s_mem  [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] exp_ct [256];
  logic [7:0] keep_pt[256];
  int         exp_len;

  int total = 0;
  int bad   = 0;
  int busy_cycles = 0;
  int ct_writes   = 0;

  arc4_encrypt #(.KEY_BYTES(KB)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .s_rddata(s_rddata),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
  );

  always #5 clk = ~clk;

  // Synchronous memories with 1-cycle read latency.
  always @(posedge clk) begin
    if (s_wren) s_mem[s_addr] <= s_wrdata;
    s_rddata  <= s_mem[s_addr];
    pt_rddata <= pt_mem[pt_addr];
    if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Textbook ARC4 over the current pt_mem image.
  function automatic void arc4_model(input logic [8*KB-1:0] k);
    int s[256];
    int i, j, t, len;
    for (int n = 0; n < 256; n++) s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + int'((k >> (8 * (KB - 1 - (n % KB)))) & 'hFF)) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    len = int'(pt_mem[0]);
    exp_len = len;
    exp_ct[0] = pt_mem[0];
    i = 0; j = 0;
    for (int n = 1; n <= len; n++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      exp_ct[n] = 8'(s[(s[i] + s[j]) % 256]) ^ pt_mem[n];
    end
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (!rdy) busy_cycles++;
      if (rdy) chk("idle_strobes", {30'd0, s_wren, ct_wren}, 32'd0);
      if (ct_wren) begin
        ct_writes++;
        chk("ct_addr_in_range", {31'd0, int'(ct_addr) <= exp_len}, 32'd1);
        chk("ct_write_data", {24'd0, ct_wrdata}, {24'd0, exp_ct[ct_addr]});
      end
    end
  end

  task automatic start(input logic [8*KB-1:0] k);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy && n < 10000) begin @(negedge clk); n++; end
    chk("ready_before_start", {31'd0, rdy}, 32'd1);
    arc4_model(k);
    busy_cycles = 0;
    ct_writes   = 0;
    key = k;
    en  = 1'b1;
    @(negedge clk);
    en  = 1'b0;
  endtask

  task automatic finish(input int busy_at, input logic [8*KB-1:0] other_key);
    int n;
    int miss;
    for (n = 0; n < 8000; n++) begin
      if (rdy) break;
      if (n == busy_at) begin en = 1'b1; key = other_key; end
      else en = 1'b0;
      @(negedge clk);
    end
    en = 1'b0;
    chk("run_completes", {31'd0, rdy}, 32'd1);
    chk("busy_cycles", busy_cycles, 1795 + 9 * exp_len);
    chk("ct_write_count", ct_writes, exp_len + 1);
    miss = 0;
    for (int a = 0; a <= exp_len; a++) if (ct_mem[a] !== exp_ct[a]) miss++;
    chk("ct_image", miss, 0);
  endtask

  task automatic fill_random(input int len);
    pt_mem[0] = 8'(len);
    for (int a = 1; a < 256; a++) pt_mem[a] = 8'($urandom);
  endtask

  initial begin
    string      msg;
    logic [7:0] kat [9];
    logic [8*KB-1:0] rk;
    int n;
    kat = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    msg = "Plaintext";

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rdy", {31'd0, rdy}, 32'd1);
    chk("rst_strobes", {30'd0, s_wren, ct_wren}, 32'd0);
    chk("rst_addrs", {s_addr, pt_addr, ct_addr, 8'd0}, 32'd0);
    chk("rst_wrdata", {16'd0, s_wrdata, ct_wrdata}, 32'd0);
    rst = 1'b0;

    // Known-answer vector; also pins the model
    pt_mem[0] = 8'd9;
    for (int a = 0; a < 9; a++) pt_mem[a + 1] = msg[a];
    arc4_model(24'h4B6579);
    for (int a = 0; a < 9; a++) chk("model_kat", {24'd0, exp_ct[a + 1]}, {24'd0, kat[a]});
    start(24'h4B6579);
    finish(-1, '0);
    chk("kat_ct0", {24'd0, ct_mem[0]}, 32'h09);
    for (int a = 0; a < 9; a++) chk("kat_ct", {24'd0, ct_mem[a + 1]}, {24'd0, kat[a]});

    // Empty message
    pt_mem[0] = 8'h00;
    ct_mem[0] = 8'h5A;
    start(24'h000000);
    finish(-1, '0);
    chk("empty_ct0", {24'd0, ct_mem[0]}, 32'h00);
    repeat (10) @(negedge clk);
    chk("empty_writes_after", ct_writes, 1);

    // Maximum message, all zero plaintext
    pt_mem[0] = 8'hFF;
    for (int a = 1; a < 256; a++) pt_mem[a] = 8'h00;
    start(24'h1F2E3D);
    finish(-1, '0);
    chk("max_ct0", {24'd0, ct_mem[0]}, 32'hFF);

    // Reset during PRGA byte 5, then rerun with the same key
    fill_random(20);
    start(24'hC0FFEE);
    n = 0;
    while (!(ct_wren && ct_addr == 8'd4) && n < 4000) begin @(negedge clk); n++; end
    chk("reached_byte4", {31'd0, ct_wren}, 32'd1);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrun_rst_rdy", {31'd0, rdy}, 32'd1);
    chk("midrun_rst_strobes", {30'd0, s_wren, ct_wren}, 32'd0);
    chk("midrun_rst_addrs", {s_addr, pt_addr, ct_addr, s_wrdata}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst_idle", {31'd0, rdy}, 32'd1);
    start(24'hC0FFEE);
    finish(-1, '0);

    // en with another key while busy (in KSA) must be ignored
    fill_random(16);
    start(24'h0A0B0C);
    finish(300, 24'hF5F4F3);

    // Random keys and messages, last one round-tripped
    for (int r = 0; r < 4; r++) begin
      rk = 24'($urandom);
      fill_random(int'($urandom_range(1, 40)));
      start(rk);
      finish(-1, '0);
    end
    for (int a = 0; a < 256; a++) keep_pt[a] = pt_mem[a];
    for (int a = 0; a <= exp_len; a++) pt_mem[a] = ct_mem[a];
    start(rk);
    finish(-1, '0);
    n = 0;
    for (int a = 0; a <= exp_len; a++) if (ct_mem[a] !== keep_pt[a]) n++;
    chk("round_trip", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
